// File: rtl/mem_data_arbiter.sv
// Round-robin arbiter sharing the OTTER memory data port between
// the CPU load/store unit (A) and a loader/debug master (B).
module mem_data_arbiter #(
  parameter int unsigned       ADDR_W  = 32,
  parameter logic [ADDR_W-1:0] IO_BASE = 32'h11000000
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              A_REQ,
  input  logic [ADDR_W-1:0] A_ADDR,
  input  logic [31:0]       A_WDATA,
  input  logic              A_WE,
  input  logic [1:0]        A_SIZE,
  input  logic              A_SIGN,
  input  logic              B_REQ,
  input  logic [ADDR_W-1:0] B_ADDR,
  input  logic [31:0]       B_WDATA,
  input  logic              B_WE,
  input  logic [1:0]        B_SIZE,
  input  logic              B_SIGN,
  output logic              A_GNT,
  output logic              A_RVALID,
  output logic [31:0]       A_RDATA,
  output logic              A_ERR,
  output logic              B_GNT,
  output logic              B_RVALID,
  output logic [31:0]       B_RDATA,
  output logic              B_ERR,
  output logic              BUSY,
  output logic [ADDR_W-1:0] MEM_ADDR2,
  output logic [31:0]       MEM_DIN2,
  output logic              MEM_WRITE2,
  output logic              MEM_READ2,
  output logic [1:0]        MEM_SIZE,
  output logic              MEM_SIGN,
  input  logic [31:0]       MEM_DOUT2
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WR,
    S_RD,
    S_RESP
  } state_t;

  state_t            r_state;
  logic              r_last;
  logic              r_owner;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic              r_we;
  logic [1:0]        r_size;
  logic              r_sign;
  logic              r_a_rvalid;
  logic              r_b_rvalid;
  logic              r_a_err;
  logic              r_b_err;
  logic [31:0]       r_a_rdata;
  logic [31:0]       r_b_rdata;

  logic              w_idle;
  logic              w_sel_b;
  logic              w_gnt_a;
  logic              w_gnt_b;
  logic [ADDR_W-1:0] w_addr;
  logic [31:0]       w_wdata;
  logic              w_we;
  logic [1:0]        w_size;
  logic              w_sign;
  logic              w_mis;
  logic              w_illegal;

  // r_last: 1 = B won last; B wins only when A is idle or A won last
  assign w_idle  = (r_state == S_IDLE) & RST_N;
  assign w_sel_b = B_REQ & (~A_REQ | ~r_last);
  assign w_gnt_a = w_idle & A_REQ & ~w_sel_b;
  assign w_gnt_b = w_idle & w_sel_b;

  assign w_addr  = w_sel_b ? B_ADDR  : A_ADDR;
  assign w_wdata = w_sel_b ? B_WDATA : A_WDATA;
  assign w_we    = w_sel_b ? B_WE    : A_WE;
  assign w_size  = w_sel_b ? B_SIZE  : A_SIZE;
  assign w_sign  = w_sel_b ? B_SIGN  : A_SIGN;

  // MMIO space takes any alignment
  assign w_mis =
    (w_size == 2'd3) |
    ((w_size == 2'd1) & w_addr[0]) |
    ((w_size == 2'd2) & (|w_addr[1:0]));
  assign w_illegal = (w_addr < IO_BASE) & w_mis;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state    <= S_IDLE;
      r_last     <= 1'b1;
      r_owner    <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_we       <= 1'b0;
      r_size     <= 2'd0;
      r_sign     <= 1'b0;
      r_a_rvalid <= 1'b0;
      r_b_rvalid <= 1'b0;
      r_a_err    <= 1'b0;
      r_b_err    <= 1'b0;
      r_a_rdata  <= '0;
      r_b_rdata  <= '0;
    end else begin
      r_a_rvalid <= 1'b0;
      r_b_rvalid <= 1'b0;
      r_a_err    <= 1'b0;
      r_b_err    <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_gnt_a | w_gnt_b) begin
            r_addr  <= w_addr;
            r_wdata <= w_wdata;
            r_we    <= w_we;
            r_size  <= w_size;
            r_sign  <= w_sign;
            r_owner <= w_sel_b;
            r_last  <= w_sel_b;
            if (w_illegal) begin
              if (w_sel_b) begin
                r_b_err <= 1'b1;
                if (!w_we) begin
                  r_b_rvalid <= 1'b1;
                  r_b_rdata  <= '0;
                end
              end else begin
                r_a_err <= 1'b1;
                if (!w_we) begin
                  r_a_rvalid <= 1'b1;
                  r_a_rdata  <= '0;
                end
              end
            end else begin
              r_state <= w_we ? S_WR : S_RD;
            end
          end
        end
        S_WR: r_state <= S_IDLE;
        S_RD: r_state <= S_RESP;
        S_RESP: begin
          r_state <= S_IDLE;
          if (r_owner) begin
            r_b_rdata  <= MEM_DOUT2;
            r_b_rvalid <= 1'b1;
          end else begin
            r_a_rdata  <= MEM_DOUT2;
            r_a_rvalid <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign A_GNT    = w_gnt_a;
  assign B_GNT    = w_gnt_b;
  assign A_RVALID = r_a_rvalid;
  assign B_RVALID = r_b_rvalid;
  assign A_RDATA  = r_a_rdata;
  assign B_RDATA  = r_b_rdata;
  assign A_ERR    = r_a_err;
  assign B_ERR    = r_b_err;
  assign BUSY     = (r_state != S_IDLE);

  // address/size/sign stay on the latch through RESP for memory slicing
  assign MEM_ADDR2  = r_addr;
  assign MEM_DIN2   = r_wdata;
  assign MEM_SIZE   = r_size;
  assign MEM_SIGN   = r_sign;
  assign MEM_WRITE2 = (r_state == S_WR);
  assign MEM_READ2  = (r_state == S_RD);

endmodule

// File: tb/tb_mem_data_arbiter.sv
// Directed bench for mem_data_arbiter with a small word memory model
// and a load-response scoreboard.
module tb_mem_data_arbiter;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        A_REQ, B_REQ;
  logic [31:0] A_ADDR, B_ADDR;
  logic [31:0] A_WDATA, B_WDATA;
  logic        A_WE, B_WE;
  logic [1:0]  A_SIZE, B_SIZE;
  logic        A_SIGN, B_SIGN;
  logic        A_GNT, B_GNT;
  logic        A_RVALID, B_RVALID;
  logic [31:0] A_RDATA, B_RDATA;
  logic        A_ERR, B_ERR;
  logic        BUSY;
  logic [31:0] MEM_ADDR2;
  logic [31:0] MEM_DIN2;
  logic        MEM_WRITE2;
  logic        MEM_READ2;
  logic [1:0]  MEM_SIZE;
  logic        MEM_SIGN;
  logic [31:0] MEM_DOUT2;

  mem_data_arbiter dut (
    .CLK(CLK), .RST_N(RST_N),
    .A_REQ(A_REQ), .A_ADDR(A_ADDR), .A_WDATA(A_WDATA),
    .A_WE(A_WE), .A_SIZE(A_SIZE), .A_SIGN(A_SIGN),
    .B_REQ(B_REQ), .B_ADDR(B_ADDR), .B_WDATA(B_WDATA),
    .B_WE(B_WE), .B_SIZE(B_SIZE), .B_SIGN(B_SIGN),
    .A_GNT(A_GNT), .A_RVALID(A_RVALID),
    .A_RDATA(A_RDATA), .A_ERR(A_ERR),
    .B_GNT(B_GNT), .B_RVALID(B_RVALID),
    .B_RDATA(B_RDATA), .B_ERR(B_ERR),
    .BUSY(BUSY),
    .MEM_ADDR2(MEM_ADDR2), .MEM_DIN2(MEM_DIN2),
    .MEM_WRITE2(MEM_WRITE2), .MEM_READ2(MEM_READ2),
    .MEM_SIZE(MEM_SIZE), .MEM_SIGN(MEM_SIGN),
    .MEM_DOUT2(MEM_DOUT2)
  );

  always #5 CLK = ~CLK;

  // word memory indexed by address bits [9:2], written only by the DUT
  logic [31:0] mem [0:255];
  always @(posedge CLK) begin
    if (MEM_WRITE2) mem[MEM_ADDR2[9:2]] <= MEM_DIN2;
  end
  assign MEM_DOUT2 = mem[MEM_ADDR2[9:2]];

  typedef struct {
    bit          port;
    logic [31:0] data;
    bit          err;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (A_RVALID || B_RVALID) begin
      if (sb.size() == 0) begin
        chk("rv_unexpected", {30'd0, A_RVALID, B_RVALID}, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("rv_port", {31'd0, B_RVALID}, {31'd0, mon_e.port});
        chk("rv_both", {31'd0, A_RVALID & B_RVALID}, 32'd0);
        chk("rv_data", mon_e.port ? B_RDATA : A_RDATA, mon_e.data);
        chk("rv_err", mon_e.port ? B_ERR : A_ERR, {31'd0, mon_e.err});
      end
    end
  end

  task automatic set_req(bit p, logic r, logic [31:0] a,
                         logic [31:0] d, logic w, logic [1:0] s);
    if (p) begin
      B_REQ = r; B_ADDR = a; B_WDATA = d;
      B_WE = w; B_SIZE = s; B_SIGN = 1'b0;
    end else begin
      A_REQ = r; A_ADDR = a; A_WDATA = d;
      A_WE = w; A_SIZE = s; A_SIGN = 1'b0;
    end
  endtask

  task automatic do_store(bit p, logic [31:0] a, logic [31:0] d,
                          logic [1:0] s, bit exp_err);
    @(negedge CLK); set_req(p, 1'b1, a, d, 1'b1, s); #1;
    chk("st_gnt", p ? B_GNT : A_GNT, 32'd1);
    chk("st_gnt_other", p ? A_GNT : B_GNT, 32'd0);
    @(negedge CLK); set_req(p, 1'b0, a, d, 1'b1, s); #1;
    chk("st_err", p ? B_ERR : A_ERR, {31'd0, exp_err});
    chk("st_rv", p ? B_RVALID : A_RVALID, 32'd0);
    chk("st_we", MEM_WRITE2, {31'd0, !exp_err});
    if (!exp_err) begin
      chk("st_addr", MEM_ADDR2, a);
      chk("st_din", MEM_DIN2, d);
      @(negedge CLK); #1;
    end
    chk("st_busy", BUSY, 32'd0);
    chk("st_we0", MEM_WRITE2, 32'd0);
  endtask

  task automatic do_load(bit p, logic [31:0] a, logic [1:0] s,
                         logic [31:0] exp_d, bit exp_err);
    exp_t e;
    @(negedge CLK); set_req(p, 1'b1, a, 32'd0, 1'b0, s); #1;
    chk("ld_gnt", p ? B_GNT : A_GNT, 32'd1);
    e.port = p;
    e.data = exp_err ? 32'd0 : exp_d;
    e.err  = exp_err;
    sb.push_back(e);
    @(negedge CLK); set_req(p, 1'b0, a, 32'd0, 1'b0, s); #1;
    chk("ld_rd", MEM_READ2, {31'd0, !exp_err});
    chk("ld_err", p ? B_ERR : A_ERR, {31'd0, exp_err});
    if (!exp_err) begin
      chk("ld_addr", MEM_ADDR2, a);
      @(negedge CLK); #1;
      chk("ld_hold_addr", MEM_ADDR2, a);
      chk("ld_hold_size", {30'd0, MEM_SIZE}, {30'd0, s});
      chk("ld_rd0", MEM_READ2, 32'd0);
      chk("ld_busy1", BUSY, 32'd1);
      @(negedge CLK); #1;
      chk("ld_rv", p ? B_RVALID : A_RVALID, 32'd1);
    end else begin
      chk("ld_rv", p ? B_RVALID : A_RVALID, 32'd1);
    end
    chk("ld_busy0", BUSY, 32'd0);
  endtask

  initial begin
    bit ea, eb;
    RST_N = 1'b0;
    set_req(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 2'd0);
    set_req(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 2'd0);
    repeat (3) @(negedge CLK);
    #1;
    chk("rst_agnt", A_GNT, 32'd0);
    chk("rst_bgnt", B_GNT, 32'd0);
    chk("rst_arv", A_RVALID, 32'd0);
    chk("rst_brv", B_RVALID, 32'd0);
    chk("rst_aerr", A_ERR, 32'd0);
    chk("rst_berr", B_ERR, 32'd0);
    chk("rst_ard", A_RDATA, 32'd0);
    chk("rst_brd", B_RDATA, 32'd0);
    chk("rst_we", MEM_WRITE2, 32'd0);
    chk("rst_rd", MEM_READ2, 32'd0);
    chk("rst_busy", BUSY, 32'd0);
    RST_N = 1'b1;

    // store then load back
    do_store(1'b0, 32'h100, 32'hDEADBEEF, 2'd2, 1'b0);
    do_load(1'b0, 32'h100, 2'd2, 32'hDEADBEEF, 1'b0);
    do_store(1'b0, 32'h200, 32'h11112222, 2'd2, 1'b0);
    do_store(1'b1, 32'h300, 32'h33334444, 2'd2, 1'b0);

    // fresh reset so A wins the first tie
    @(negedge CLK); RST_N = 1'b0;
    @(negedge CLK); RST_N = 1'b1;

    // both requesting loads continuously
    set_req(1'b0, 1'b1, 32'h200, 32'd0, 1'b0, 2'd2);
    set_req(1'b1, 1'b1, 32'h300, 32'd0, 1'b0, 2'd2);
    for (int k = 0; k < 12; k++) begin
      if (k > 0) @(negedge CLK);
      #1;
      ea = (k % 6 == 0);
      eb = (k % 6 == 3);
      chk("rr_agnt", A_GNT, {31'd0, ea});
      chk("rr_bgnt", B_GNT, {31'd0, eb});
      chk("rr_ard", A_RDATA, (k >= 3) ? 32'h11112222 : 32'd0);
      chk("rr_brd", B_RDATA, (k >= 6) ? 32'h33334444 : 32'd0);
      if (ea) sb.push_back('{1'b0, 32'h11112222, 1'b0});
      if (eb) sb.push_back('{1'b1, 32'h33334444, 1'b0});
      #3;
    end
    @(negedge CLK);
    set_req(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 2'd0);
    set_req(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 2'd0);
    #1;
    chk("rr_idle_gnt", {31'd0, A_GNT | B_GNT}, 32'd0);

    // illegal and boundary accesses
    do_load(1'b0, 32'h102, 2'd2, 32'd0, 1'b1);
    do_load(1'b0, 32'h103, 2'd1, 32'd0, 1'b1);
    do_load(1'b0, 32'h101, 2'd1, 32'd0, 1'b1);
    do_load(1'b0, 32'h100, 2'd3, 32'd0, 1'b1);
    do_load(1'b0, 32'h10FFFFFE, 2'd2, 32'd0, 1'b1);
    do_load(1'b1, 32'h106, 2'd2, 32'd0, 1'b1);
    do_load(1'b0, 32'h102, 2'd1, 32'hDEADBEEF, 1'b0);
    do_store(1'b0, 32'h104, 32'h55555555, 2'd3, 1'b1);
    do_store(1'b0, 32'h11000002, 32'hCAFEF00D, 2'd2, 1'b0);

    // reset during the RESP cycle of a B load
    @(negedge CLK); set_req(1'b1, 1'b1, 32'h300, 32'd0, 1'b0, 2'd2); #1;
    chk("ab_gnt", B_GNT, 32'd1);
    @(negedge CLK); set_req(1'b1, 1'b0, 32'h300, 32'd0, 1'b0, 2'd2); #1;
    chk("ab_rd", MEM_READ2, 32'd1);
    @(negedge CLK); RST_N = 1'b0; #1;
    chk("ab_busy", BUSY, 32'd1);
    @(negedge CLK); #1;
    chk("ab_brv", B_RVALID, 32'd0);
    chk("ab_berr", B_ERR, 32'd0);
    chk("ab_brd", B_RDATA, 32'd0);
    chk("ab_ard", A_RDATA, 32'd0);
    chk("ab_busy0", BUSY, 32'd0);
    chk("ab_rd0", MEM_READ2, 32'd0);
    RST_N = 1'b1;
    @(negedge CLK);
    set_req(1'b0, 1'b1, 32'h200, 32'd0, 1'b0, 2'd2);
    set_req(1'b1, 1'b1, 32'h300, 32'd0, 1'b0, 2'd2);
    #1;
    chk("ab_first_a", A_GNT, 32'd1);
    chk("ab_first_b", B_GNT, 32'd0);
    chk("ab_brv2", B_RVALID, 32'd0);
    sb.push_back('{1'b0, 32'h11112222, 1'b0});
    @(negedge CLK); set_req(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 2'd0); #1;
    chk("ab_wait_b1", B_GNT, 32'd0);
    @(negedge CLK); #1;
    chk("ab_wait_b2", B_GNT, 32'd0);
    @(negedge CLK); #1;
    chk("ab_b_gnt", B_GNT, 32'd1);
    sb.push_back('{1'b1, 32'h33334444, 1'b0});
    @(negedge CLK); set_req(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 2'd0);
    repeat (4) @(negedge CLK);
    #1;
    chk("sb_drained", sb.size(), 32'd0);
    chk("end_busy", BUSY, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_data_arbiter.md
Name: mem_data_arbiter

Overview:
- Shares the single data port of the byte-addressable OTTER memory (port 2) between two requesters.
- Port A is the CPU load/store unit; port B is a program loader / debug master.
- Round-robin arbitration; each winning request is latched and sequenced through the memory's one-cycle synchronous read.
- Misaligned requests are rejected before they reach memory.

Parameters:
- ADDR_W, 32, address width of both requester ports and the memory port.
- IO_BASE, 32'h11000000, addresses at or above this bypass the alignment check (MMIO region).

Ports:
- CLK  in  1  system clock, all logic on rising edge
- RST_N  in  1  synchronous, active-low reset
- A_REQ, B_REQ  in  1  request valid; held with fields until the matching GNT
- A_ADDR, B_ADDR  in  ADDR_W  byte address
- A_WDATA, B_WDATA  in  32  store data, right-aligned
- A_WE, B_WE  in  1  1 = store, 0 = load
- A_SIZE, B_SIZE  in  2  0 = byte, 1 = half, 2 = word; 3 is illegal
- A_SIGN, B_SIGN  in  1  1 = unsigned load
- A_GNT, B_GNT  out  1  one-cycle accept pulse
- A_RVALID, B_RVALID  out  1  one-cycle load-complete pulse
- A_RDATA, B_RDATA  out  32  load data, valid with RVALID
- A_ERR, B_ERR  out  1  one-cycle misaligned/illegal pulse
- BUSY  out  1  state != IDLE
- MEM_ADDR2  out  32  to memory data port
- MEM_DIN2  out  32  to memory data port
- MEM_WRITE2  out  1  to memory data port
- MEM_READ2  out  1  to memory data port
- MEM_SIZE  out  2  to memory data port
- MEM_SIGN  out  1  to memory data port
- MEM_DOUT2  in  32  sliced load data from memory

Behaviour:
- Reset (RST_N low at a CLK edge):
  - state = IDLE, LAST = B, so A wins the first tie.
  - All GNT, RVALID and ERR outputs 0; RDATA = 0.
  - MEM_WRITE2 = 0, MEM_READ2 = 0; latched request fields cleared.
  - Reset mid-transaction abandons it: no RVALID or ERR is issued afterwards.
- States: IDLE, WR, RD, RESP.
- IDLE:
  - Winner selection: if only one REQ is high, that port wins. If both are high, the port != LAST wins.
  - GNT to the winner is combinational in the same cycle.
  - On the edge: latch the winner's ADDR, WDATA, WE, SIZE and SIGN; set the owner ID; set LAST = winner.
  - Illegal condition, checked only when ADDR < IO_BASE:
    - SIZE = 3
    - SIZE = 1 with ADDR[0] = 1
    - SIZE = 1 with ADDR[1:0] = 3
    - SIZE = 2 with ADDR[1:0] != 0
  - Illegal request: still granted. Next cycle pulse owner ERR; for a load also pulse RVALID with RDATA = 0. Stay in IDLE with no memory access.
  - Legal request: go to WR if WE = 1, else RD.
- WR (1 cycle): MEM_WRITE2 = 1, memory bus driven from the latch. Next state IDLE.
- RD (1 cycle): MEM_READ2 = 1. Next state RESP.
- RESP (1 cycle): MEM_READ2 = 0. MEM_ADDR2, MEM_SIZE and MEM_SIGN held from the latch, because the memory slices combinationally on the current address. On the edge, owner RDATA <= MEM_DOUT2 and owner RVALID = 1 in the following cycle. Next state IDLE.
- Memory bus fields always reflect the latch. MEM_WRITE2 and MEM_READ2 are 0 outside WR and RD.
- Latency and throughput:
  - Store: GNT at cycle t, memory write at t+1, next grant possible at t+2.
  - Load: GNT at t, RVALID at t+3. RVALID coincides with the next IDLE, so a new grant can occur in the same cycle.
- Requests arriving while not in IDLE wait; REQ must be held.
- Never grant both ports in one cycle.
- The non-owner's RDATA is unchanged on another port's load.

Test Plan:
- Reset, then A store: A_REQ=1, A_ADDR=0x100, A_WDATA=0xDEADBEEF, SIZE=2 -> A_GNT at t, MEM_WRITE2=1 with MEM_ADDR2=0x100 at t+1, BUSY low at t+2.
- A load back from 0x100, SIZE=2, memory returns 0xDEADBEEF -> MEM_READ2 at t+1, address held through t+2, A_RVALID with A_RDATA=0xDEADBEEF at t+3.
- Both REQ high continuously, loads -> grants alternate A, B, A, B (A first after reset), one grant per 3 cycles, B_RDATA untouched during A's reads.
- A_REQ word load at 0x102 -> A_GNT, A_ERR and A_RVALID with A_RDATA=0 next cycle, MEM_READ2 never asserted.
- A_REQ word store at 0x11000002 (>= IO_BASE) -> no ERR, MEM_WRITE2=1.
- RST_N low during RESP of a B load -> B_RVALID never pulses, all outputs 0, next A request is granted first.
